snd_out_stage: RTL
==================

// Module: snd_out_stage
// PURPOSE
//  Output conditioner directly downstream of the logistic-map PWM synth.
//  - Takes its 1-bit PWM audio and decimates it into DEC_LOG2-bit window samples.
//  - Applies a click-free stepped volume/mute envelope.
//  - Re-modulates the result as first-order sigma-delta to drive the audio pin.
// PARAMETERS
//  DEC_LOG2   6   window length = 2^DEC_LOG2 clocks; sample/accumulator width
//  GAIN_BITS  4   gain/volume width; gain 2^GAIN_BITS-1 ~ unity
// PORTS
//  clk           in   1          clock; the single clock domain
//  rst_n         in   1          reset, asynchronous, active LOW
//  pwm_in        in   1          PWM audio from the synth stage
//  vol_in        in   GAIN_BITS  target volume; read only at window end
//  mute          in   1          level: 1 = ramp to silence; read at window end
//  audio_out     out  1          sigma-delta audio to pin
//  sample_out    out  DEC_LOG2   last decimated sample (pre-gain)
//  sample_valid  out  1          1-cycle pulse when sample_out updates
//  muted         out  1          1 while FSM is in MUTED
// BEHAVIOUR
//  Reset: async assert, sync deassert at the block boundary. While rst_n=0:
//   - win_cnt, ones_cnt, sample_out, sample_valid, gain, level and sd_acc are 0.
//   - audio_out=0, muted=0, state=UP (soft start on release).
//  Decimator:
//   - win_cnt free-runs 0..2^DEC_LOG2-1; win_end = (win_cnt==max).
//   - ones_cnt (DEC_LOG2+1 bits) accumulates pwm_in every cycle, including
//     the win_end cycle.
//   - On win_end: sample_out <= min(total, 2^DEC_LOG2-1), i.e. a full window
//     of 1s saturates to 63. ones_cnt restarts at 0 for the next window.
//   - sample_valid is high the cycle after win_end, for 1 cycle.
//  Gain: level <= (sample * gain) >> GAIN_BITS.
//   - The product is DEC_LOG2+GAIN_BITS bits, truncated, no rounding.
//   - It uses the new sample and the gain value before this window's step.
//   - level updates in the same cycle as sample_out.
//  FSM (states UP, RUN, DOWN, MUTED): evaluated and gain stepped only on win_end.
//   - UP:    mute -> DOWN (gain-1, floor 0).
//            else if gain<vol_in -> gain+1; when gain+1==vol_in -> RUN.
//            else -> RUN, no step.
//   - RUN:   mute -> DOWN (gain-1, floor 0).
//            else step gain 1 toward vol_in; hold if equal.
//   - DOWN:  mute=0 -> UP, no step.
//            else gain-1; when gain reaches 0 -> MUTED.
//   - MUTED: gain held 0; mute=0 -> UP.
//   - Gain changes at most 1 LSB per window; it never wraps.
//   - vol_in/mute changes between window ends are ignored.
//  Sigma-delta: sd_acc is DEC_LOG2+1 bits.
//   - Each cycle: {carry, sd_acc} <= sd_acc[DEC_LOG2-1:0] + level.
//   - audio_out <= carry.
//   - Ones density over any 2^DEC_LOG2-cycle span = level/2^DEC_LOG2, +/-1.
//   - level=0 gives audio_out constantly 0.
// STRUCTURE
//  - Shared header snd_defs: FSM state encodings (2-bit UP/RUN/DOWN/MUTED) and
//    the DEC_LOG2/GAIN_BITS defaults.
//  - One sub-module: snd_sigma_delta (clk, rst_n, level, audio_out).
//  - Decimator, gain multiply and FSM stay in the top.
// TESTING (DEC_LOG2=6, GAIN_BITS=4)
//  1. pwm_in=1, vol_in=15, mute=0 from reset:
//     - sample_valid every 64 clks, sample_out=63.
//     - gain 0->15 over 15 windows, then RUN.
//     - final level=59, audio_out density 59/64.
//  2. pwm_in alternating 1,0, gain settled at 8:
//     - sample_out=32, level=16, audio_out 16 ones per 64 clks.
//  3. RUN gain 15, mute=1:
//     - gain 15->0 in 15 windows; muted rises on the 15th win_end.
//     - audio_out stuck 0.
//     - mute=0 -> UP at next win_end.
//  4. RUN gain 15, vol_in=4: gain steps down 1/window to 4, then holds.
//     vol_in glitch 4->9->4 inside one window: no gain change.
//  5. rst_n low mid-window (win_cnt=20), async:
//     - all outputs 0 within the same cycle.
//     - after release, first sample_valid exactly 65 clks later.
//  6. mute=1 at a win_end while in UP with gain=3:
//     - DOWN with gain=2; gain 0 two windows later, then MUTED.

Source files
------------

// File: rtl/snd_defs.sv
// Shared definitions for the sound output stage: envelope FSM encodings and
// default decimation/gain widths.
package snd_defs;

    localparam int DEC_LOG2_DEF  = 6;
    localparam int GAIN_BITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_UP    = 2'd0,
        ST_RUN   = 2'd1,
        ST_DOWN  = 2'd2,
        ST_MUTED = 2'd3
    } snd_state_e;

endpackage

// File: rtl/snd_sigma_delta.sv
// First-order sigma-delta re-modulator: the carry out of a DEC_LOG2-bit
// phase accumulator gives a ones density of level/2^DEC_LOG2.
module snd_sigma_delta
    import snd_defs::*;
#(
    parameter int DEC_LOG2 = DEC_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DEC_LOG2-1:0] level,
    output logic                audio_out
);

    // Top bit holds the carry of the last add and drives the pin directly.
    logic [DEC_LOG2:0] sd_acc_q;
    logic [DEC_LOG2:0] sd_acc_d;

    always_comb begin
        sd_acc_d = {1'b0, sd_acc_q[DEC_LOG2-1:0]} + {1'b0, level};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_acc_q <= '0;
        end else begin
            sd_acc_q <= sd_acc_d;
        end
    end

    assign audio_out = sd_acc_q[DEC_LOG2];

endmodule

// File: rtl/snd_out_stage.sv
// Output conditioner: decimates 1-bit PWM into window samples, applies a
// stepped volume/mute envelope and re-modulates the result as sigma-delta.
module snd_out_stage
    import snd_defs::*;
#(
    parameter int DEC_LOG2  = DEC_LOG2_DEF,
    parameter int GAIN_BITS = GAIN_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    input  logic [GAIN_BITS-1:0] vol_in,
    input  logic                 mute,
    output logic                 audio_out,
    output logic [DEC_LOG2-1:0]  sample_out,
    output logic                 sample_valid,
    output logic                 muted
);

    localparam int PW = DEC_LOG2 + GAIN_BITS;
    localparam logic [DEC_LOG2-1:0] WIN_MAX = '1;

    // A full window of ones counts to 2^DEC_LOG2, one more than a sample holds.
    function automatic logic [DEC_LOG2-1:0] sat_sample(input logic [DEC_LOG2:0] total);
        return total[DEC_LOG2] ? '1 : total[DEC_LOG2-1:0];
    endfunction

    logic [DEC_LOG2-1:0]  win_cnt_q, win_cnt_d;
    logic [DEC_LOG2:0]    ones_cnt_q, ones_cnt_d;
    logic [DEC_LOG2-1:0]  sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic [GAIN_BITS-1:0] gain_q, gain_d;
    logic [DEC_LOG2-1:0]  level_q, level_d;
    snd_state_e           state_q, state_d;
    logic                 muted_q, muted_d;

    logic                 win_end;
    logic [DEC_LOG2:0]    ones_total;
    logic [DEC_LOG2-1:0]  new_sample;
    logic [PW-1:0]        product;
    logic [GAIN_BITS-1:0] gain_inc, gain_dec;

    always_comb begin
        win_end        = (win_cnt_q == WIN_MAX);
        ones_total     = ones_cnt_q + {{DEC_LOG2{1'b0}}, pwm_in};
        new_sample     = sat_sample(ones_total);
        product        = PW'(new_sample) * PW'(gain_q);
        gain_inc       = gain_q + GAIN_BITS'(1);
        gain_dec       = (gain_q == '0) ? '0 : gain_q - GAIN_BITS'(1);

        win_cnt_d      = win_cnt_q + DEC_LOG2'(1);
        ones_cnt_d     = win_end ? '0 : ones_total;
        sample_valid_d = win_end;
        sample_d       = sample_q;
        level_d        = level_q;
        gain_d         = gain_q;
        state_d        = state_q;

        // Level uses the gain in force before this window's envelope step.
        if (win_end) begin
            sample_d = new_sample;
            level_d  = DEC_LOG2'(product >> GAIN_BITS);
            case (state_q)
                ST_UP: begin
                    if (mute) begin
                        state_d = ST_DOWN;
                        gain_d  = gain_dec;
                    end else if (gain_q < vol_in) begin
                        gain_d = gain_inc;
                        if (gain_inc == vol_in) state_d = ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mute) begin
                        state_d = ST_DOWN;
                        gain_d  = gain_dec;
                    end else if (gain_q < vol_in) begin
                        gain_d = gain_inc;
                    end else if (gain_q > vol_in) begin
                        gain_d = gain_dec;
                    end
                end
                ST_DOWN: begin
                    if (!mute) begin
                        state_d = ST_UP;
                    end else begin
                        gain_d = gain_dec;
                        if (gain_dec == '0) state_d = ST_MUTED;
                    end
                end
                ST_MUTED: begin
                    gain_d = '0;
                    if (!mute) state_d = ST_UP;
                end
                default: state_d = ST_UP;
            endcase
        end

        muted_d = (state_d == ST_MUTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q      <= '0;
            ones_cnt_q     <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            gain_q         <= '0;
            level_q        <= '0;
            state_q        <= ST_UP;
            muted_q        <= 1'b0;
        end else begin
            win_cnt_q      <= win_cnt_d;
            ones_cnt_q     <= ones_cnt_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            gain_q         <= gain_d;
            level_q        <= level_d;
            state_q        <= state_d;
            muted_q        <= muted_d;
        end
    end

    snd_sigma_delta #(
        .DEC_LOG2(DEC_LOG2)
    ) u_sigma_delta (
        .clk      (clk),
        .rst_n    (rst_n),
        .level    (level_q),
        .audio_out(audio_out)
    );

    assign sample_out   = sample_q;
    assign sample_valid = sample_valid_q;
    assign muted        = muted_q;

endmodule
